udma_tx_prefetch: RTL and testbench
===================================

UDMA_TX_PREFETCH -- requirements
Module: udma_tx_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the data word on both the channel side and the peripheral side.
REQ-002 SHALL have parameter DEPTH, default 4, the number of buffer entries; it is a power of two and at least 2.
REQ-003 SHALL have clk_i, input, 1 bit: the clock; all state is updated on its rising edge.
REQ-004 SHALL have rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have cfg_en_i, input, 1 bit: level enable for prefetching.
REQ-006 SHALL have cfg_clr_i, input, 1 bit: single-cycle pulse that flushes the buffer.
REQ-007 SHALL have cfg_datasize_i, input, 2 bits: forwarded transfer size (00 byte, 01 half-word, 10 word).
REQ-008 SHALL have cfg_dest_i, input, 2 bits: forwarded destination code.
REQ-009 SHALL have req_o, input gnt_i, each 1 bit: request/grant pair toward the TX channel.
REQ-010 SHALL have datasize_o and dest_o, outputs, 2 bits each: wired directly from cfg_datasize_i and cfg_dest_i.
REQ-011 SHALL have valid_i (input, 1), data_i (input, DATA_WIDTH) and ready_o (output, 1): the response from the TX channel.
REQ-012 SHALL have out_valid_o (output, 1), out_data_o (output, DATA_WIDTH) and out_ready_i (input, 1): the data stream toward the peripheral.
REQ-013 SHALL have level_o, output, $clog2(DEPTH)+1 bits: current buffer occupancy.
REQ-014 SHALL have busy_o, output, 1 bit: high whenever state != IDLE.

Function
REQ-015 SHALL have three states: IDLE, RUN and DRAIN.
  - IDLE->RUN when cfg_en_i=1.
  - RUN->DRAIN when cfg_en_i=0 or cfg_clr_i=1.
  - DRAIN->RUN when cfg_en_i=1, outstanding=0 and cfg_clr_i=0.
  - DRAIN->IDLE when cfg_en_i=0 and outstanding=0.
REQ-016 SHALL keep an outstanding counter, width $clog2(DEPTH)+1.
  - +1 on req_o&gnt_i.
  - -1 on an accepted valid_i.
  - Both events in the same cycle: the counter is unchanged.
REQ-017 SHALL assert req_o combinationally when state=RUN and (outstanding+level) < DEPTH; a granted read therefore always has a slot reserved for it.
REQ-018 SHALL hold ready_o constantly at 1; by construction of REQ-017 a response never meets a full buffer.
REQ-019 SHALL write data_i into the buffer on valid_i unless the discard flag is set.
REQ-020 SHALL drive out_valid_o=(level!=0) and out_data_o=head entry, and SHALL pop the head on out_valid_o&out_ready_i.
REQ-021 SHALL, on a simultaneous push and pop, leave level unchanged; on a push while full, drop the data and hold an internal overflow flag (checked by assertion).
REQ-022 SHALL, on cfg_clr_i:
  - zero the level and the read/write pointers the next cycle;
  - set the discard flag while outstanding!=0;
  - clear the discard flag once outstanding returns to 0.
REQ-023 SHALL have a minimum latency of one cycle from valid_i to out_valid_o (without the macro of REQ-027).
REQ-024 SHALL use pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.

Reset
REQ-025 SHALL, on reset, set state=IDLE and clear outstanding, level, both pointers, the discard flag and the overflow flag.
REQ-026 SHALL drive outputs during reset as req_o=0, out_valid_o=0, level_o=0, busy_o=0, ready_o=1; the buffer contents are not reset.

Configuration
REQ-027 SHALL support macro UDMA_TX_PREFETCH_BYPASS_EN.
  - Defined: when level=0 and valid_i=1 with discard=0, out_valid_o=1 and out_data_o=data_i in the same cycle. If out_ready_i=1 in that cycle the word is not written.
  - Undefined: all data passes through the buffer with one-cycle latency.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/DRAIN) and the datasize codes in the shared package udma_pkg.
REQ-029 SHALL implement the storage as one sub-module, udma_tx_prefetch_ram: a DEPTH x DATA_WIDTH register array with write and read ports; the control logic stays in the top module.

Verification
REQ-030 SHALL cover these directed scenarios:
  - Reset, then cfg_en_i=1, gnt_i=1 always, valid_i returned 2 cycles after each grant, out_ready_i=0 -> exactly 4 grants, level_o=4, req_o=0 afterwards.
  - Same setup, then out_ready_i=1 for 1 cycle -> one pop, req_o=1 for exactly one more grant.
  - Words 0x11223344, 0x55667788 returned -> appear on out_data_o in that order, no duplication.
  - cfg_clr_i with 2 reads outstanding -> level_o=0 next cycle, both responses discarded, out_valid_o stays 0, busy_o drops once outstanding=0 and cfg_en_i=0.
  - Grant and valid_i in the same cycle with outstanding=1 -> outstanding remains 1.
  - With UDMA_TX_PREFETCH_BYPASS_EN defined, empty buffer, valid_i=1, data_i=0xA5, out_ready_i=1 -> out_valid_o=1 and out_data_o=0xA5 in the same cycle, level_o stays 0.

Source files
------------

// File: rtl/udma_pkg.sv
// Shared uDMA definitions: TX prefetch state encoding, transfer-size codes
// and a width helper for occupancy and outstanding-read counters.
package udma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } udma_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } udma_datasize_e;

    // A counter that must reach DEPTH itself needs one bit more than a pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/udma_tx_prefetch_ram.sv
// DEPTH x DATA_WIDTH register array for the TX prefetch buffer:
// one synchronous write port and one combinational read port.
module udma_tx_prefetch_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the level counter alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/udma_tx_prefetch.sv
// uDMA TX prefetch buffer: issues reads toward the TX channel while a slot is
// free and streams returned words to the peripheral. Optional same-cycle
// bypass of an empty buffer is enabled with `define UDMA_TX_PREFETCH_BYPASS_EN.
module udma_tx_prefetch
    import udma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_clr_i,
    input  logic [1:0]              cfg_datasize_i,
    input  logic [1:0]              cfg_dest_i,
    output logic                    req_o,
    input  logic                    gnt_i,
    output logic [1:0]              datasize_o,
    output logic [1:0]              dest_o,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    ready_o,
    output logic                    out_valid_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    input  logic                    out_ready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

    udma_state_e           state_q, state_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         level_q, level_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic                  discard_q, discard_d;
    logic                  overflow_q;
    logic [CW:0]           reserved;
    logic                  grant, push, pop, wr_en, empty, full;
    logic [DATA_WIDTH-1:0] head;

    assign ready_o    = 1'b1;
    assign datasize_o = cfg_datasize_i;
    assign dest_o     = cfg_dest_i;
    assign level_o    = level_q;
    assign busy_o     = (state_q != IDLE);

    assign empty = (level_q == '0);
    assign full  = (level_q == CW'(DEPTH));

    // Counting in-flight reads against free slots guarantees every response has room.
    assign reserved = {1'b0, outstanding_q} + {1'b0, level_q};
    assign req_o    = (state_q == RUN) && (reserved < DEPTH_EXT);
    assign grant    = req_o & gnt_i;
    assign pop      = ~empty & out_ready_i;

`ifdef UDMA_TX_PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass      = empty & valid_i & ~discard_q;
    assign out_valid_o = ~empty | bypass;
    assign out_data_o  = empty ? data_i : head;
    assign push        = valid_i & ~discard_q & ~(bypass & out_ready_i);
`else
    assign out_valid_o = ~empty;
    assign out_data_o  = head;
    assign push        = valid_i & ~discard_q;
`endif

    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({grant, valid_i})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        level_d = level_q;
        if (cfg_clr_i) begin
            level_d = '0;
        end else begin
            unique case ({wr_en, pop})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
        end

        // Responses to reads issued before a flush are dropped until none remain.
        discard_d = (cfg_clr_i | discard_q) & (outstanding_d != '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_en_i) state_d = RUN;
            RUN:     if (!cfg_en_i || cfg_clr_i) state_d = DRAIN;
            DRAIN: begin
                if (outstanding_q == '0) begin
                    if (!cfg_en_i)       state_d = IDLE;
                    else if (!cfg_clr_i) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            discard_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            level_q       <= level_d;
            discard_q     <= discard_d;
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (cfg_clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    udma_tx_prefetch_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_en & ~cfg_clr_i),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    overflow_never_set: assert property (@(posedge clk_i) disable iff (!rstn_i) !overflow_q);

endmodule

// File: tb/tb_udma_tx_prefetch.sv
// Self-checking bench for udma_tx_prefetch: a queue-based model of the buffer,
// an in-order TX channel responder and directed plus randomized scenarios.
module tb_udma_tx_prefetch;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cfg_en_i, cfg_clr_i;
    logic [1:0]    cfg_datasize_i, cfg_dest_i;
    logic          req_o, gnt_i;
    logic [1:0]    datasize_o, dest_o;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic [2:0]    level_o;
    logic          busy_o;

    udma_tx_prefetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_clr_i      (cfg_clr_i),
        .cfg_datasize_i (cfg_datasize_i),
        .cfg_dest_i     (cfg_dest_i),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .datasize_o     (datasize_o),
        .dest_o         (dest_o),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_ready_i    (out_ready_i),
        .level_o        (level_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        bit          flushed;
        logic [31:0] data;
    } resp_t;

    resp_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] forced[$];
    logic [31:0] obs[$];
    int          m_state, cyc, grants, lat_min, lat_max;
    int          total, bad;
    logic        cap_out_valid;
    logic [31:0] cap_out_data;

    // One clock of stimulus and checking; entered and left just after a falling edge.
    task automatic cycle();
        resp_t       r;
        bit          do_resp, flushed, exp_req, exp_ov, had_head, consumed;
        logic [31:0] exp_dat;
        int          out_cur;
        do_resp = (pend.size() > 0) && (pend[0].due <= cyc);
        flushed = do_resp && pend[0].flushed;
        valid_i = do_resp;
        data_i  = do_resp ? pend[0].data : $urandom;
        #1;
        out_cur = pend.size();
        exp_req = (m_state == S_RUN) && (out_cur + mq.size() < DEPTH);
        exp_ov  = (mq.size() != 0);
        exp_dat = exp_ov ? mq[0] : 32'h0;
`ifdef UDMA_TX_PREFETCH_BYPASS_EN
        if (!exp_ov && do_resp && !flushed) begin
            exp_ov  = 1'b1;
            exp_dat = data_i;
        end
`endif
        total++; if (req_o !== exp_req) begin bad++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, req_o, exp_req); end
        total++; if (out_valid_o !== exp_ov) begin bad++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, exp_ov); end
        if (exp_ov) begin
            total++; if (out_data_o !== exp_dat) begin bad++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data_o, exp_dat); end
        end
        total++; if (level_o !== 3'(mq.size())) begin bad++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level_o, mq.size()); end
        total++; if (busy_o !== (m_state != S_IDLE)) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, m_state != S_IDLE); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ready cyc=%0d got=%b exp=1", cyc, ready_o); end
        total++; if ({datasize_o, dest_o} !== {cfg_datasize_i, cfg_dest_i}) begin bad++; $display("FAIL cfg_fwd cyc=%0d got=%h exp=%h", cyc, {datasize_o, dest_o}, {cfg_datasize_i, cfg_dest_i}); end
        cap_out_valid = out_valid_o;
        cap_out_data  = out_data_o;
        if (out_valid_o && out_ready_i) obs.push_back(out_data_o);
        @(posedge clk_i);
        had_head = (mq.size() != 0);
        consumed = 1'b0;
        if (had_head && out_ready_i) void'(mq.pop_front());
`ifdef UDMA_TX_PREFETCH_BYPASS_EN
        consumed = !had_head && do_resp && !flushed && out_ready_i;
`endif
        if (do_resp) begin
            r = pend.pop_front();
            if (!r.flushed && !consumed) mq.push_back(r.data);
        end
        if (exp_req && gnt_i) begin
            grants++;
            r.due     = cyc + $urandom_range(lat_min, lat_max);
            r.flushed = 1'b0;
            r.data    = (forced.size() > 0) ? forced.pop_front() : $urandom;
            pend.push_back(r);
        end
        if (cfg_clr_i) begin
            mq.delete();
            foreach (pend[i]) pend[i].flushed = 1'b1;
        end
        case (m_state)
            S_IDLE:  if (cfg_en_i) m_state = S_RUN;
            S_RUN:   if (!cfg_en_i || cfg_clr_i) m_state = S_DRAIN;
            default: if (out_cur == 0) begin
                         if (!cfg_en_i) m_state = S_IDLE;
                         else if (!cfg_clr_i) m_state = S_RUN;
                     end
        endcase
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic drain_to_idle();
        bit done = 1'b0;
        cfg_en_i = 1'b0; cfg_clr_i = 1'b0; gnt_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_state == S_IDLE && pend.size() == 0 && mq.size() == 0) done = 1'b1;
            else cycle();
        end
        total++; if (!done) begin bad++; $display("FAIL drain_timeout got=busy exp=idle"); end
        total++; if (busy_o !== 1'b0 || level_o !== 3'd0) begin bad++; $display("FAIL drain_idle got busy=%b level=%0d exp busy=0 level=0", busy_o, level_o); end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; cfg_en_i = 1'b1; cfg_clr_i = 1'b0; gnt_i = 1'b1;
        valid_i = 1'b0; data_i = '0; out_ready_i = 1'b0;
        cfg_datasize_i = 2'b10; cfg_dest_i = 2'b01;
        pend.delete(); mq.delete(); m_state = S_IDLE; cyc = 0; grants = 0;
        repeat (3) @(negedge clk_i);
        #1;
        total++; if (req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
        cfg_en_i = 1'b0; gnt_i = 1'b0;
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_fill();
        int g0 = grants;
        lat_min = 2; lat_max = 2;
        cfg_en_i = 1'b1; gnt_i = 1'b1; out_ready_i = 1'b0;
        repeat (14) cycle();
        total++; if (grants - g0 != 4) begin bad++; $display("FAIL fill_grants got=%0d exp=4", grants - g0); end
        total++; if (level_o !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", level_o); end
        total++; if (req_o !== 1'b0) begin bad++; $display("FAIL fill_req got=%b exp=0", req_o); end
        out_ready_i = 1'b1;
        cycle();
        out_ready_i = 1'b0;
        repeat (6) cycle();
        total++; if (grants - g0 != 5) begin bad++; $display("FAIL refill_grants got=%0d exp=5", grants - g0); end
        total++; if (level_o !== 3'd4) begin bad++; $display("FAIL refill_level got=%0d exp=4", level_o); end
        drain_to_idle();
    endtask

    task automatic test_order();
        int g0 = grants;
        obs.delete();
        forced.push_back(32'h11223344);
        forced.push_back(32'h55667788);
        lat_min = 2; lat_max = 2;
        cfg_en_i = 1'b1; out_ready_i = 1'b1;
        repeat (10) begin
            gnt_i = (grants - g0) < 2;
            cycle();
        end
        total++; if (obs.size() != 2) begin bad++; $display("FAIL order_count got=%0d exp=2", obs.size()); end
        if (obs.size() == 2) begin
            total++; if (obs[0] !== 32'h11223344 || obs[1] !== 32'h55667788) begin bad++; $display("FAIL order_data got=%h,%h exp=11223344,55667788", obs[0], obs[1]); end
        end
        drain_to_idle();
    endtask

    task automatic test_clear();
        int  g0 = grants;
        int  n_obs;
        bit  saw_valid = 1'b0, dropped = 1'b0;
        lat_min = 3; lat_max = 3;
        cfg_en_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 10 && pend.size() < 2; i++) begin
            gnt_i = (grants - g0) < 2;
            cycle();
        end
        total++; if (pend.size() != 2) begin bad++; $display("FAIL clr_setup got=%0d exp=2", pend.size()); end
        n_obs = obs.size();
        cfg_clr_i = 1'b1; cfg_en_i = 1'b0; gnt_i = 1'b0;
        cycle();
        cfg_clr_i = 1'b0;
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL clr_level got=%0d exp=0", level_o); end
        for (int i = 0; i < 20 && !dropped; i++) begin
            cycle();
            saw_valid |= out_valid_o;
            if (!busy_o) dropped = 1'b1;
        end
        total++; if (!dropped) begin bad++; $display("FAIL clr_busy_drop got=busy exp=idle"); end
        total++; if (saw_valid || obs.size() != n_obs) begin bad++; $display("FAIL clr_discard got valid=%b words=%0d exp valid=0 words=0", saw_valid, obs.size() - n_obs); end
        total++; if (pend.size() != 0) begin bad++; $display("FAIL clr_outstanding got=%0d exp=0", pend.size()); end
        drain_to_idle();
    endtask

    task automatic test_grant_and_valid();
        lat_min = 1; lat_max = 1;
        cfg_en_i = 1'b1; gnt_i = 1'b0; out_ready_i = 1'b1;
        cycle();
        gnt_i = 1'b1;
        cycle();
        cycle();
        gnt_i = 1'b0;
        total++; if (dut.outstanding_q !== 3'd1 || pend.size() != 1) begin bad++; $display("FAIL same_cycle_outstanding got=%0d exp=1", dut.outstanding_q); end
        drain_to_idle();
    endtask

`ifdef UDMA_TX_PREFETCH_BYPASS_EN
    task automatic test_bypass();
        lat_min = 2; lat_max = 2;
        forced.push_back(32'h000000A5);
        cfg_en_i = 1'b1; gnt_i = 1'b0; out_ready_i = 1'b1;
        cycle();
        gnt_i = 1'b1;
        cycle();
        gnt_i = 1'b0; cfg_en_i = 1'b0;
        cycle();
        cycle();
        total++; if (cap_out_valid !== 1'b1 || cap_out_data !== 32'hA5) begin bad++; $display("FAIL bypass got valid=%b data=%h exp valid=1 data=a5", cap_out_valid, cap_out_data); end
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL bypass_level got=%0d exp=0", level_o); end
        drain_to_idle();
    endtask
`endif

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            cfg_en_i       = ($urandom_range(0, 9) != 0);
            cfg_clr_i      = ($urandom_range(0, 29) == 0);
            gnt_i          = $urandom_range(0, 1);
            out_ready_i    = $urandom_range(0, 1);
            cfg_datasize_i = 2'($urandom_range(0, 2));
            cfg_dest_i     = 2'($urandom_range(0, 3));
            cycle();
        end
        cfg_clr_i = 1'b0;
        drain_to_idle();
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_fill();
        test_order();
        test_clear();
        test_grant_and_valid();
`ifdef UDMA_TX_PREFETCH_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
